// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and sequencing controller for the five-stage pipeline.
// Combines three hazard sources and drives the pipeline-register controls:
//   - multi-cycle data-memory wait (freeze the whole pipe)
//   - taken branch resolved in MEM (redirect PC, flush IF/ID, ID/EX, EX/MEM)
//   - load-use between the load in EX and its consumer in ID (one bubble)
// Priority while running: memory wait > branch flush > load-use.
// A memory wait that lasts TIMEOUT cycles parks the FSM in ERROR (frozen pipe,
// sticky mem_error) until reset.
//
// Handshake: the MEM-stage access is a request (mem_re | mem_we) that is
// complete in any cycle where dmem_ready is high; there is no separate valid
// phase, so every cycle with a request and no ready is a wait cycle.
//
// Ports
//   clk, reset (async, active-low)
//   id_rs1, id_rs2, id_uses_rs1, id_uses_rs2   ID-stage source operands
//   ex_rd, ex_mem_re, ex_reg_file_write        ID/EX destination / load info
//   mem_re, mem_we, mem_branch_taken           EX/MEM control outputs
//   dmem_ready                                 data memory completes access
//   cnt_clr                                    synchronous counter clear
//   pc_write, pc_sel_branch                    PC controls
//   if_id_write, if_id_flush                   IF/ID controls
//   id_ex_hold, id_ex_flush                    ID/EX controls
//   ex_mem_hold, ex_mem_flush                  EX/MEM controls
//   mem_wb_bubble                              MEM/WB bubble insert
//   mem_error                                  sticky memory-timeout error
//   stall_cnt, flush_cnt                       saturating perf counters
//   dbg_state                                  current FSM state (debug)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int WAIT_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_re,
  input  logic             ex_reg_file_write,
  input  logic             mem_re,
  input  logic             mem_we,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W+1)'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              mem_req;
  logic              mem_wait;
  logic              load_use;
  logic [WAIT_W:0]   wait_cycles;
  logic              err_set;
  logic              flush_evt;
  logic              stall_inc;

  assign mem_req  = mem_re | mem_we;
  assign mem_wait = mem_req & ~dmem_ready;
  assign load_use = ex_mem_re & ex_reg_file_write & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Number of wait cycles including the current one: the first wait cycle is
  // seen in RUN, later ones in MEM_WAIT. The T-th consecutive wait cycle ends
  // in ERROR, so mem_error is visible from cycle T+1.
  assign wait_cycles = (state_q == ST_MEM_WAIT) ? ({1'b0, wait_cnt_q} + 1'b1)
                                                : {{WAIT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    err_set       = 1'b0;
    flush_evt     = 1'b0;
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;

    case (state_q)
      ST_ERROR: begin
        // Frozen pipe regardless of inputs; only reset leaves ERROR.
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      default: begin
        if (mem_wait) begin
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          if (wait_cycles == TIMEOUT_V) begin
            state_d = ST_ERROR;
            err_set = 1'b1;
          end else begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = wait_cycles[WAIT_W-1:0];
          end
        end else begin
          // Access done (or none): release into normal hazard handling.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (mem_branch_taken) begin
            // Any load-use in ID/EX is on the wrong path and is discarded.
            flush_evt     = 1'b1;
            pc_write      = 1'b1;
            pc_sel_branch = 1'b1;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
          end else if (load_use) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
      end
    endcase

    // Hold every control low while reset is asserted.
    if (!reset) begin
      pc_write      = 1'b0;
      pc_sel_branch = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_hold    = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_hold   = 1'b0;
      ex_mem_flush  = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

  assign stall_inc = (state_q != ST_ERROR) & ~pc_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (err_set) begin
        mem_error_q <= 1'b1;
      end
      if (cnt_clr) begin
        stall_cnt_q <= '0;
        flush_cnt_q <= '0;
      end else begin
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
        if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
        end
      end
    end
  end

  assign mem_error = mem_error_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for pipeline_hazard_ctrl. Two instances share all inputs:
//   dut_a: TIMEOUT=255, CNT_W=16 (main behaviour, long random run)
//   dut_b: TIMEOUT=4,   CNT_W=2  (timeout and counter saturation)
// Expected values come from directed constants and from a cycle model that
// tracks consecutive wait cycles, error flag and counters as plain integers.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_re = 0, ex_reg_file_write = 0;
  logic mem_re = 0, mem_we = 0, mem_branch_taken = 0, dmem_ready = 0, cnt_clr = 0;

  logic pc_write_a, pc_sel_branch_a, if_id_write_a, if_id_flush_a, id_ex_hold_a;
  logic id_ex_flush_a, ex_mem_hold_a, ex_mem_flush_a, mem_wb_bubble_a, mem_error_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [1:0] dbg_state_a;
  logic pc_write_b, pc_sel_branch_b, if_id_write_b, if_id_flush_b, id_ex_hold_b;
  logic id_ex_flush_b, ex_mem_hold_b, ex_mem_flush_b, mem_wb_bubble_b, mem_error_b;
  logic [1:0] stall_cnt_b, flush_cnt_b;
  logic [1:0] dbg_state_b;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT(255), .WAIT_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_re(ex_mem_re), .ex_reg_file_write(ex_reg_file_write),
    .mem_re(mem_re), .mem_we(mem_we), .mem_branch_taken(mem_branch_taken),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_write(pc_write_a), .pc_sel_branch(pc_sel_branch_a),
    .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
    .id_ex_hold(id_ex_hold_a), .id_ex_flush(id_ex_flush_a),
    .ex_mem_hold(ex_mem_hold_a), .ex_mem_flush(ex_mem_flush_a),
    .mem_wb_bubble(mem_wb_bubble_a), .mem_error(mem_error_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .dbg_state(dbg_state_a)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(4), .WAIT_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_re(ex_mem_re), .ex_reg_file_write(ex_reg_file_write),
    .mem_re(mem_re), .mem_we(mem_we), .mem_branch_taken(mem_branch_taken),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_write(pc_write_b), .pc_sel_branch(pc_sel_branch_b),
    .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
    .id_ex_hold(id_ex_hold_b), .id_ex_flush(id_ex_flush_b),
    .ex_mem_hold(ex_mem_hold_b), .ex_mem_flush(ex_mem_flush_b),
    .mem_wb_bubble(mem_wb_bubble_b), .mem_error(mem_error_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .dbg_state(dbg_state_b)
  );

  // Control vector: {pc_write, pc_sel_branch, if_id_write, if_id_flush,
  //                  id_ex_hold, id_ex_flush, ex_mem_hold, ex_mem_flush, mem_wb_bubble}
  localparam logic [8:0] CTL_ZERO   = 9'b000000000;
  localparam logic [8:0] CTL_FREEZE = 9'b000010101;
  localparam logic [8:0] CTL_FLUSH  = 9'b111101010;
  localparam logic [8:0] CTL_LU     = 9'b000001000;
  localparam logic [8:0] CTL_NORMAL = 9'b101000000;

  logic [8:0]  d_ctl   [2];
  logic [15:0] d_stall [2];
  logic [15:0] d_flush [2];
  logic        d_err   [2];

  assign d_ctl[0] = {pc_write_a, pc_sel_branch_a, if_id_write_a, if_id_flush_a,
                     id_ex_hold_a, id_ex_flush_a, ex_mem_hold_a, ex_mem_flush_a,
                     mem_wb_bubble_a};
  assign d_ctl[1] = {pc_write_b, pc_sel_branch_b, if_id_write_b, if_id_flush_b,
                     id_ex_hold_b, id_ex_flush_b, ex_mem_hold_b, ex_mem_flush_b,
                     mem_wb_bubble_b};
  assign d_stall[0] = stall_cnt_a;
  assign d_stall[1] = {14'd0, stall_cnt_b};
  assign d_flush[0] = flush_cnt_a;
  assign d_flush[1] = {14'd0, flush_cnt_b};
  assign d_err[0]   = mem_error_a;
  assign d_err[1]   = mem_error_b;

  int total = 0;
  int bad   = 0;

  // Reference model state per instance.
  int m_t   [2] = '{255, 4};
  int m_max [2] = '{65535, 3};
  int m_run   [2];
  int m_stall [2];
  int m_flush [2];
  bit m_err   [2];

  function automatic logic [8:0] model_ctl(input bit err);
    bit wt, lu;
    wt = (mem_re || mem_we) && !dmem_ready;
    lu = ex_mem_re && ex_reg_file_write && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!reset)           return CTL_ZERO;
    if (err || wt)        return CTL_FREEZE;
    if (mem_branch_taken) return CTL_FLUSH;
    if (lu)               return CTL_LU;
    return CTL_NORMAL;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_re = 0; ex_reg_file_write = 0; mem_re = 0; mem_we = 0;
    mem_branch_taken = 0; dmem_ready = 0; cnt_clr = 0;
  endtask

  // Advance the model with the current inputs, then clock the DUTs.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      bit wt;
      logic [8:0] e;
      wt = (mem_re || mem_we) && !dmem_ready;
      e  = model_ctl(m_err[i]);
      if (cnt_clr) begin
        m_stall[i] = 0;
        m_flush[i] = 0;
      end else begin
        if (!m_err[i] && !e[8] && m_stall[i] < m_max[i]) m_stall[i]++;
        if (!m_err[i] && !wt && mem_branch_taken && m_flush[i] < m_max[i]) m_flush[i]++;
      end
      if (!m_err[i]) begin
        if (wt) begin
          m_run[i]++;
          if (m_run[i] == m_t[i]) m_err[i] = 1;
        end else begin
          m_run[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_load_use();
    ex_mem_re = 1; ex_reg_file_write = 1; ex_rd = 5'd5;
    id_uses_rs1 = 1; id_rs1 = 5'd7; id_uses_rs2 = 1; id_rs2 = 5'd5;
  endtask

  task automatic test_reset();
    mem_re = 1; dmem_ready = 0; mem_branch_taken = 1; set_load_use();
    reset = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (d_ctl[i] !== CTL_ZERO) begin
        bad++; $display("FAIL reset_ctl[%0d] got=%b exp=%b", i, d_ctl[i], CTL_ZERO);
      end
      total++;
      if (d_stall[i] !== 16'd0 || d_flush[i] !== 16'd0 || d_err[i] !== 1'b0) begin
        bad++; $display("FAIL reset_regs[%0d] got stall=%0d flush=%0d err=%b exp 0/0/0",
                        i, d_stall[i], d_flush[i], d_err[i]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (d_ctl[0] !== CTL_ZERO || d_stall[0] !== 16'd0) begin
      bad++; $display("FAIL reset_hold got ctl=%b stall=%0d exp ctl=%b stall=0",
                      d_ctl[0], d_stall[0], CTL_ZERO);
    end
    clear_inputs();
    reset = 1'b1;
    #2;
    total++;
    if (d_ctl[0] !== CTL_NORMAL) begin
      bad++; $display("FAIL reset_release got=%b exp=%b", d_ctl[0], CTL_NORMAL);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #2;
    total++;
    if (d_ctl[0] !== CTL_LU) begin
      bad++; $display("FAIL load_use_ctl got=%b exp=%b", d_ctl[0], CTL_LU);
    end
    tick();
    // EX now holds the bubble: no load there any more.
    ex_mem_re = 0; ex_reg_file_write = 0;
    #2;
    total++;
    if (d_ctl[0] !== CTL_NORMAL) begin
      bad++; $display("FAIL load_use_after got=%b exp=%b", d_ctl[0], CTL_NORMAL);
    end
    total++;
    if (d_stall[0] !== 16'd1) begin
      bad++; $display("FAIL load_use_stall_cnt got=%0d exp=1", d_stall[0]);
    end
    tick();
  endtask

  task automatic test_rd_zero();
    do_reset();
    ex_mem_re = 1; ex_reg_file_write = 1; ex_rd = 0; id_uses_rs1 = 1; id_rs1 = 0;
    #2;
    total++;
    if (d_ctl[0] !== CTL_NORMAL) begin
      bad++; $display("FAIL rd_zero_ctl got=%b exp=%b", d_ctl[0], CTL_NORMAL);
    end
    tick();
    total++;
    if (d_stall[0] !== 16'd0) begin
      bad++; $display("FAIL rd_zero_stall_cnt got=%0d exp=0", d_stall[0]);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_re = 1; dmem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      total++;
      if (d_ctl[0] !== CTL_FREEZE) begin
        bad++; $display("FAIL mem_wait_ctl[%0d] got=%b exp=%b", k, d_ctl[0], CTL_FREEZE);
      end
      tick();
    end
    dmem_ready = 1;
    #2;
    total++;
    if (d_ctl[0] !== CTL_NORMAL) begin
      bad++; $display("FAIL mem_release_ctl got=%b exp=%b", d_ctl[0], CTL_NORMAL);
    end
    total++;
    if (d_stall[0] !== 16'd3) begin
      bad++; $display("FAIL mem_wait_stall_cnt got=%0d exp=3", d_stall[0]);
    end
    tick();
    // Back in RUN: a ready-on-first-cycle access causes no stall.
    #2;
    total++;
    if (d_ctl[0] !== CTL_NORMAL || d_stall[0] !== 16'd3) begin
      bad++; $display("FAIL mem_ready_first got ctl=%b stall=%0d exp ctl=%b stall=3",
                      d_ctl[0], d_stall[0], CTL_NORMAL);
    end
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    set_load_use();
    mem_branch_taken = 1;
    #2;
    total++;
    if (d_ctl[0] !== CTL_FLUSH) begin
      bad++; $display("FAIL branch_ctl got=%b exp=%b", d_ctl[0], CTL_FLUSH);
    end
    tick();
    clear_inputs();
    #2;
    total++;
    if (d_flush[0] !== 16'd1 || d_stall[0] !== 16'd0) begin
      bad++; $display("FAIL branch_cnts got flush=%0d stall=%0d exp flush=1 stall=0",
                      d_flush[0], d_stall[0]);
    end
    tick();
  endtask

  task automatic test_wait_vs_branch();
    do_reset();
    mem_we = 1; dmem_ready = 0; mem_branch_taken = 1;
    for (int k = 0; k < 2; k++) begin
      #2;
      total++;
      if (d_ctl[0] !== CTL_FREEZE) begin
        bad++; $display("FAIL wait_branch_ctl[%0d] got=%b exp=%b", k, d_ctl[0], CTL_FREEZE);
      end
      tick();
    end
    total++;
    if (d_flush[0] !== 16'd0) begin
      bad++; $display("FAIL wait_branch_flush_cnt got=%0d exp=0", d_flush[0]);
    end
    dmem_ready = 1;
    #2;
    total++;
    if (d_ctl[0] !== CTL_FLUSH) begin
      bad++; $display("FAIL release_flush_ctl got=%b exp=%b", d_ctl[0], CTL_FLUSH);
    end
    tick();
    total++;
    if (d_flush[0] !== 16'd1 || d_stall[0] !== 16'd2) begin
      bad++; $display("FAIL release_flush_cnts got flush=%0d stall=%0d exp flush=1 stall=2",
                      d_flush[0], d_stall[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_we = 1; dmem_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      #2;
      total++;
      if (d_err[1] !== 1'b0 || d_ctl[1] !== CTL_FREEZE) begin
        bad++; $display("FAIL timeout_cycle[%0d] got err=%b ctl=%b exp err=0 ctl=%b",
                        k, d_err[1], d_ctl[1], CTL_FREEZE);
      end
      tick();
    end
    #2;
    total++;
    if (d_err[1] !== 1'b1 || d_err[0] !== 1'b0) begin
      bad++; $display("FAIL timeout_err got b=%b a=%b exp b=1 a=0", d_err[1], d_err[0]);
    end
    // ERROR ignores inputs; the long-timeout instance reacts normally.
    mem_we = 0; dmem_ready = 1; mem_branch_taken = 1;
    #2;
    total++;
    if (d_ctl[1] !== CTL_FREEZE || d_ctl[0] !== CTL_FLUSH) begin
      bad++; $display("FAIL error_frozen got b=%b a=%b exp b=%b a=%b",
                      d_ctl[1], d_ctl[0], CTL_FREEZE, CTL_FLUSH);
    end
    tick();
    total++;
    if (d_stall[1] !== 16'd3 || d_err[1] !== 1'b1 || d_flush[1] !== 16'd0) begin
      bad++; $display("FAIL error_regs got stall=%0d err=%b flush=%0d exp 3/1/0",
                      d_stall[1], d_err[1], d_flush[1]);
    end
    // Asynchronous reset out of ERROR.
    reset = 1'b0;
    model_reset();
    #2;
    total++;
    if (d_err[1] !== 1'b0 || d_ctl[1] !== CTL_ZERO) begin
      bad++; $display("FAIL error_reset got err=%b ctl=%b exp err=0 ctl=%b",
                      d_err[1], d_ctl[1], CTL_ZERO);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    reset = 1'b1;
    #2;
    total++;
    if (d_ctl[1] !== CTL_NORMAL) begin
      bad++; $display("FAIL error_recover got=%b exp=%b", d_ctl[1], CTL_NORMAL);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    for (int k = 0; k < 5; k++) tick();
    #2;
    total++;
    if (d_stall[1] !== 16'd3 || d_stall[0] !== 16'd5) begin
      bad++; $display("FAIL stall_saturate got b=%0d a=%0d exp b=3 a=5", d_stall[1], d_stall[0]);
    end
    cnt_clr = 1;
    #2;
    total++;
    if (d_ctl[1] !== CTL_LU) begin
      bad++; $display("FAIL clr_stall_ctl got=%b exp=%b", d_ctl[1], CTL_LU);
    end
    tick();
    total++;
    if (d_stall[1] !== 16'd0 || d_stall[0] !== 16'd0) begin
      bad++; $display("FAIL cnt_clr got b=%0d a=%0d exp 0/0", d_stall[1], d_stall[0]);
    end
    cnt_clr = 0;
  endtask

  task automatic test_random();
    logic [8:0] e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      mem_re            = ($urandom_range(0, 3) == 0);
      mem_we            = ($urandom_range(0, 5) == 0);
      dmem_ready        = ($urandom_range(0, 2) != 0);
      mem_branch_taken  = ($urandom_range(0, 5) == 0);
      ex_mem_re         = ($urandom_range(0, 1) == 1);
      ex_reg_file_write = ($urandom_range(0, 3) != 0);
      ex_rd             = 5'($urandom_range(0, 3));
      id_rs1            = 5'($urandom_range(0, 3));
      id_rs2            = 5'($urandom_range(0, 3));
      id_uses_rs1       = ($urandom_range(0, 1) == 1);
      id_uses_rs2       = ($urandom_range(0, 1) == 1);
      cnt_clr           = ($urandom_range(0, 49) == 0);
      #2;
      for (int i = 0; i < 2; i++) begin
        e = model_ctl(m_err[i]);
        total++;
        if (d_ctl[i] !== e) begin
          bad++; $display("FAIL rand_ctl[%0d] cyc=%0d got=%b exp=%b", i, c, d_ctl[i], e);
        end
        total++;
        if (d_stall[i] !== 16'(m_stall[i]) || d_flush[i] !== 16'(m_flush[i])) begin
          bad++; $display("FAIL rand_cnts[%0d] cyc=%0d got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                          i, c, d_stall[i], d_flush[i], m_stall[i], m_flush[i]);
        end
        total++;
        if (d_err[i] !== m_err[i]) begin
          bad++; $display("FAIL rand_err[%0d] cyc=%0d got=%b exp=%b", i, c, d_err[i], m_err[i]);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_mem_wait();
    test_branch_vs_load_use();
    test_wait_vs_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
